switch_debouncer: RTL

//   Conditions the board slide switches before they reach the LED display controller.

---
 rtl/switch_debouncer_if.sv | 29 ++
 rtl/switch_debouncer.sv | 68 ++++++
 2 files changed

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw switch pins in, debounced levels and edge events out.
// The debouncer sits on the slave modport; the switch source / consumer side uses master.
interface switch_debouncer_if #(
    parameter int unsigned NUM_INPUTS = 15
);

    logic [NUM_INPUTS-1:0] rawInputs;
    logic [NUM_INPUTS-1:0] debouncedOutputs;
    logic [NUM_INPUTS-1:0] risingPulse;
    logic [NUM_INPUTS-1:0] fallingPulse;
    logic                  anyChange;

    modport master (
        output rawInputs,
        input  debouncedOutputs,
        input  risingPulse,
        input  fallingPulse,
        input  anyChange
    );

    modport slave (
        input  rawInputs,
        output debouncedOutputs,
        output risingPulse,
        output fallingPulse,
        output anyChange
    );

endinterface

// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: 2-flop synchroniser, stability counter, registered level
// and one-cycle rising/falling pulses. Bits are fully independent.
module switch_debouncer #(
    parameter int unsigned NUM_INPUTS    = 15,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned COUNT_WIDTH   = 20
) (
    input  logic              clk,
    input  logic              reset,
    switch_debouncer_if.slave sw
);

    // Terminal count: the mismatch that sees this value commits the new level.
    localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(STABLE_CYCLES - 1);

    logic [NUM_INPUTS-1:0]                  sync1_q, sync2_q;
    logic [NUM_INPUTS-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_INPUTS-1:0]                  deb_q, deb_d;
    logic [NUM_INPUTS-1:0]                  rise_q, rise_d;
    logic [NUM_INPUTS-1:0]                  fall_q, fall_d;
    logic                                   any_q, any_d;

    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LastCount) begin
                deb_d[i]  = sync2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
        any_d = (|rise_d) | (|fall_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= sw.rawInputs;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
        end
    end

    assign sw.debouncedOutputs = deb_q;
    assign sw.risingPulse      = rise_q;
    assign sw.fallingPulse     = fall_q;
    assign sw.anyChange        = any_q;

endmodule
